// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver: hex decode, per-digit dp,
// leading-zero blanking and frame-synchronous (tear-free) display update.
module seg7_scan_driver #(
    parameter int DIGITS     = 4,
    parameter int CLK_DIV    = 50000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_lz,
    output logic [6:0]            seg_data,
    output logic                  dp,
    output logic [DIGITS-1:0]     digit_sel,
    output logic                  frame_done
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic POL = (ACTIVE_LOW != 0);
    localparam logic [6:0] SEG_OFF = {7{POL}};

    logic [CNT_W-1:0]    cnt_reg;
    logic [IDX_W-1:0]    idx_reg;
    logic [4*DIGITS-1:0] shadow_val_reg;
    logic [DIGITS-1:0]   shadow_dp_reg;
    logic [4*DIGITS-1:0] disp_val_reg;
    logic [DIGITS-1:0]   disp_dp_reg;
    logic                pending_reg;
    logic                frame_done_reg;
    logic [6:0]          seg_reg;
    logic                dp_reg;
    logic [DIGITS-1:0]   sel_reg;

    logic                tick;
    logic                frame_end;
    logic [3:0]          nib [DIGITS];
    logic [DIGITS-1:0]   blank_vec;
    logic                all_zero;
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                cur_blank;
    logic [DIGITS-1:0]   sel_on;
    logic [6:0]          seg_on;
    logic [6:0]          seg_next;
    logic                dp_next;
    logic [DIGITS-1:0]   sel_next;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h7E;  4'h1: s = 7'h30;  4'h2: s = 7'h6D;  4'h3: s = 7'h79;
            4'h4: s = 7'h33;  4'h5: s = 7'h5B;  4'h6: s = 7'h5F;  4'h7: s = 7'h70;
            4'h8: s = 7'h7F;  4'h9: s = 7'h7B;  4'hA: s = 7'h77;  4'hB: s = 7'h1F;
            4'hC: s = 7'h4E;  4'hD: s = 7'h3D;  4'hE: s = 7'h4F;  default: s = 7'h47;
        endcase
        return s;
    endfunction

    assign tick      = (cnt_reg == CNT_LAST);
    assign frame_end = tick && (idx_reg == IDX_LAST);

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
            assign nib[gi] = disp_val_reg[4*gi +: 4];
        end
    endgenerate

    // A digit is blanked only if it and every more-significant digit are zero.
    always_comb begin
        blank_vec = '0;
        all_zero  = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            all_zero     = all_zero && (nib[i] == 4'h0);
            blank_vec[i] = all_zero && blank_lz;
        end
    end

    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        sel_on    = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_reg == IDX_W'(i)) begin
                cur_nib   = nib[i];
                cur_dp    = disp_dp_reg[i];
                cur_blank = blank_vec[i];
                sel_on[i] = 1'b1;
            end
        end
        seg_on   = cur_blank ? 7'h00 : hex_to_seg(cur_nib);
        seg_next = seg_on ^ {7{POL}};
        dp_next  = cur_dp ^ POL;
        sel_next = sel_on ^ {DIGITS{POL}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
            idx_reg <= '0;
        end else if (tick) begin
            cnt_reg <= '0;
            idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // A load landing on the frame-end tick goes straight to the display.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_val_reg <= '0;
            shadow_dp_reg  <= '0;
            disp_val_reg   <= '0;
            disp_dp_reg    <= '0;
            pending_reg    <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= frame_end;
            if (load) begin
                shadow_val_reg <= value;
                shadow_dp_reg  <= dp_in;
            end
            if (frame_end) begin
                if (load) begin
                    disp_val_reg <= value;
                    disp_dp_reg  <= dp_in;
                end else if (pending_reg) begin
                    disp_val_reg <= shadow_val_reg;
                    disp_dp_reg  <= shadow_dp_reg;
                end
                pending_reg <= 1'b0;
            end else if (load) begin
                pending_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_reg <= SEG_OFF;
            dp_reg  <= POL;
            sel_reg <= {DIGITS{POL}};
        end else begin
            seg_reg <= seg_next;
            dp_reg  <= dp_next;
            sel_reg <= sel_next;
        end
    end

    assign seg_data   = seg_reg;
    assign dp         = dp_reg;
    assign digit_sel  = sel_reg;
    assign frame_done = frame_done_reg;

endmodule
